// File: rtl/rgb2gray_mult_sched_pkg.sv
// Shared constants for the RGB-to-gray sequencer: state encoding, default
// Q0.8 weights, accumulator sizing and the rounding constant.
package rgb2gray_mult_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_R = 3'd1,
        MUL_G = 3'd2,
        MUL_B = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam logic [7:0] DEF_COEF_R = 8'd77;
    localparam logic [7:0] DEF_COEF_G = 8'd150;
    localparam logic [7:0] DEF_COEF_B = 8'd29;

    // Three 8x8 products sum to at most 195075 (+128 rounding), which fits 18 bits.
    localparam int              ACC_W = 18;
    localparam logic [ACC_W-1:0] RND  = 18'd128;

    function automatic logic [7:0] sat8(input logic [ACC_W-9:0] x);
        sat8 = (x > 10'd255) ? 8'hff : x[7:0];
    endfunction

endpackage

// File: rtl/mult_8_8.sv
// Existing unsigned 8x8 combinational multiplier shared by the gray sequencer.
module mult_8_8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    assign p = a * b;

endmodule

// File: rtl/rgb2gray_mult_sched.sv
// Per-pixel weighted RGB-to-gray conversion using one shared multiplier over
// three MAC cycles, with valid/ready on both sides.
module rgb2gray_mult_sched
    import rgb2gray_mult_sched_pkg::*;
#(
    parameter logic [7:0] COEF_R = DEF_COEF_R,
    parameter logic [7:0] COEF_G = DEF_COEF_G,
    parameter logic [7:0] COEF_B = DEF_COEF_B
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_rgb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_gray
);

    state_t             state, state_nxt;
    logic [7:0]         r_reg, g_reg, b_reg;
    logic [ACC_W-1:0]   acc;
    logic [7:0]         mul_a, mul_b;
    logic [15:0]        product;
    logic [ACC_W-1:0]   sum_rnd;
    logic               accept;

    mult_8_8 u_mult (
        .a (mul_a),
        .b (mul_b),
        .p (product)
    );

    assign accept  = in_valid & in_ready;
    assign sum_rnd = acc + ACC_W'(product) + RND;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = MUL_R;
            MUL_R:   state_nxt = MUL_G;
            MUL_G:   state_nxt = MUL_B;
            MUL_B:   state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = in_valid ? MUL_R : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_a     = 8'd0;
        mul_b     = 8'd0;
        case (state)
            IDLE: in_ready = 1'b1;
            MUL_R: begin
                mul_a = r_reg;
                mul_b = COEF_R;
            end
            MUL_G: begin
                mul_a = g_reg;
                mul_b = COEF_G;
            end
            MUL_B: begin
                mul_a = b_reg;
                mul_b = COEF_B;
            end
            OUT: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Pixel is captured only on the accept edge; the MAC chain reads the copy.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_reg    <= 8'd0;
            g_reg    <= 8'd0;
            b_reg    <= 8'd0;
            acc      <= '0;
            out_gray <= 8'd0;
        end else begin
            if (accept) begin
                r_reg <= in_rgb[23:16];
                g_reg <= in_rgb[15:8];
                b_reg <= in_rgb[7:0];
            end
            case (state)
                MUL_R:   acc      <= ACC_W'(product);
                MUL_G:   acc      <= acc + ACC_W'(product);
                MUL_B:   out_gray <= sat8(sum_rnd[ACC_W-1:8]);
                default: ;
            endcase
        end
    end

endmodule
